// File: rtl/seq_frac_divider.sv
// Iterative radix-2 restoring divider: integer quotient plus FRAC_W truncated fraction bits.
// One division in flight; request via in_valid/rfd, result via out_valid/out_ready.
module seq_frac_divider #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 16,
   parameter int FRAC_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  rfd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [FRAC_W-1:0]     fractional,
   output logic                  div_by_zero,
   output logic [1:0]            state_dbg
);

   localparam int N     = DIVIDEND_W + FRAC_W;
   localparam int CNT_W = $clog2(N);
   localparam int REM_W = DIVISOR_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Handshakes: a transfer happens on a rising clk edge where valid and
   // ready/rfd are both high; valid side holds its data stable until then.

   logic [1:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [REM_W-1:0]     rem;
   logic [DIVISOR_W-1:0] dsr;
   // Extended dividend bits leave at the top while quotient bits enter at the bottom.
   logic [N-1:0]         work;

   logic [REM_W:0]       trial;
   logic                 q_bit;
   logic [N-1:0]         work_next;

   always_comb begin
      trial     = {rem, work[N-1]};
      q_bit     = (trial >= {2'b00, dsr});
      work_next = {work[N-2:0], q_bit};
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rfd         <= 1'b1;
         out_valid   <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         fractional  <= '0;
         cnt         <= '0;
         rem         <= '0;
         dsr         <= '0;
         work        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && rfd) begin
                  rfd   <= 1'b0;
                  dsr   <= divisor;
                  work  <= {dividend, {FRAC_W{1'b0}}};
                  rem   <= '0;
                  cnt   <= '0;
                  state <= (divisor == '0) ? DONE : CALC;
               end
            end
            CALC: begin
               rem  <= REM_W'(q_bit ? (trial - {2'b00, dsr}) : trial);
               work <= work_next;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  quotient   <= work_next[N-1:FRAC_W];
                  fractional <= work_next[FRAC_W-1:0];
               end
            end
            DONE: begin
               // Arriving with out_valid low only happens on the zero-divisor path.
               if (!out_valid) begin
                  out_valid   <= 1'b1;
                  quotient    <= '1;
                  fractional  <= '1;
                  div_by_zero <= 1'b1;
               end else if (out_ready) begin
                  out_valid   <= 1'b0;
                  div_by_zero <= 1'b0;
                  rfd         <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               rfd       <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_frac_divider.sv
// Directed table vectors, multi-cycle corner sequences and a random scoreboard run
// for seq_frac_divider at default parameters.
module tb_seq_frac_divider;

   localparam int N_RAND = 300;
   localparam logic [1:0] ST_IDLE = 2'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        rfd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  fractional;
   logic        div_by_zero;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [7:0]  f;
      logic        dbz;
      int          stall;
   } vec_t;

   vec_t        vecs[10];
   logic [24:0] exp_q[$];

   int          sent, recv, cyc, saw_valid;
   bit          acc_last;
   logic [24:0] exp_v, act_v;
   logic [23:0] num, qm;

   always #5 clk = ~clk;

   seq_frac_divider dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .dividend    (dividend),
      .divisor     (divisor),
      .rfd         (rfd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .fractional  (fractional),
      .div_by_zero (div_by_zero),
      .state_dbg   (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Entered at a negedge; returns at the negedge right after the output handshake.
   task automatic do_div(input vec_t v);
      int m;
      int lat;
      lat = (v.b == 16'd0) ? 1 : 24;
      dividend = v.a;
      divisor  = v.b;
      in_valid = 1'b1;
      m = 0;
      while (!rfd && m < 200) begin
         @(negedge clk);
         m++;
      end
      check("rfd_before_accept", rfd, 1);
      @(negedge clk);
      check("rfd_after_accept", rfd, 0);
      m = 0;
      while (!out_valid && m < 100) begin
         in_valid = 1'($urandom_range(0, 1));
         dividend = 16'($urandom);
         divisor  = 16'($urandom);
         @(negedge clk);
         m++;
      end
      check("latency", m, lat);
      check("quotient", quotient, v.q);
      check("fractional", fractional, v.f);
      check("div_by_zero", div_by_zero, v.dbz);
      check("rfd_in_done", rfd, 0);
      for (int s = 0; s < v.stall; s++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         dividend  = 16'($urandom);
         divisor   = 16'($urandom);
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_quotient", quotient, v.q);
         check("stall_fractional", fractional, v.f);
         check("stall_rfd", rfd, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("valid_after_hs", out_valid, 0);
      check("rfd_after_hs", rfd, 1);
      check("dbz_after_hs", div_by_zero, 0);
      check("state_after_hs", state_dbg, ST_IDLE);
      check("quotient_hold", quotient, v.q);
      check("fractional_hold", fractional, v.f);
   endtask

   initial begin
      vecs[0] = '{16'd100,   16'd7,     16'd14,    8'd73,  1'b0, 0};
      vecs[1] = '{16'd65535, 16'd1,     16'd65535, 8'd0,   1'b0, 0};
      vecs[2] = '{16'd65535, 16'd65535, 16'd1,     8'd0,   1'b0, 0};
      vecs[3] = '{16'd1,     16'd3,     16'd0,     8'd85,  1'b0, 0};
      vecs[4] = '{16'd0,     16'd9,     16'd0,     8'd0,   1'b0, 0};
      vecs[5] = '{16'd5,     16'd0,     16'd65535, 8'd255, 1'b1, 0};
      vecs[6] = '{16'd1000,  16'd3,     16'd333,   8'd85,  1'b0, 10};
      vecs[7] = '{16'd12345, 16'd100,   16'd123,   8'd115, 1'b0, 0};
      vecs[8] = '{16'd40000, 16'd3,     16'd13333, 8'd85,  1'b0, 0};
      vecs[9] = '{16'd7,     16'd65535, 16'd0,     8'd0,   1'b0, 0};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_rfd", rfd, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_quotient", quotient, 0);
      check("reset_fractional", fractional, 0);
      check("reset_dbz", div_by_zero, 0);
      check("reset_state", state_dbg, ST_IDLE);

      for (int i = 0; i < 10; i++) do_div(vecs[i]);

      // Reset in the middle of 200/9 must drop the division silently.
      dividend = 16'd200;
      divisor  = 16'd9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_rfd", rfd, 1);
      check("midrst_state", state_dbg, ST_IDLE);
      check("midrst_quotient", quotient, 0);
      saw_valid = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw_valid++;
      end
      check("midrst_no_output", saw_valid, 0);
      do_div('{16'd3, 16'd4, 16'd0, 8'd192, 1'b0, 0});

      // Random operands with random request gaps and output backpressure.
      sent = 0;
      recv = 0;
      cyc = 0;
      acc_last = 1'b0;
      in_valid = 1'b0;
      while (recv < N_RAND && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (acc_last) begin
            in_valid = 1'b0;
            acc_last = 1'b0;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         if (out_valid && out_ready) begin
            act_v = {quotient, fractional, div_by_zero};
            if (exp_q.size() == 0) begin
               check("rand_spurious_result", 1, 0);
            end else begin
               exp_v = exp_q.pop_front();
               check("rand_result", act_v, exp_v);
            end
            recv++;
         end
         if (!in_valid && sent < N_RAND && $urandom_range(0, 2) == 0) begin
            dividend = 16'($urandom);
            if ($urandom_range(0, 15) == 0) divisor = 16'd0;
            else if ($urandom_range(0, 1) == 1) divisor = 16'($urandom);
            else divisor = 16'($urandom_range(1, 20));
            in_valid = 1'b1;
            sent++;
         end
         if (in_valid && rfd) begin
            if (divisor == 16'd0) begin
               exp_q.push_back({16'hFFFF, 8'hFF, 1'b1});
            end else begin
               num = {dividend, 8'h00};
               qm  = num / {8'h00, divisor};
               exp_q.push_back({qm, 1'b0});
            end
            acc_last = 1'b1;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("rand_result_count", recv, N_RAND);
      check("rand_sent_count", sent, N_RAND);
      check("rand_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
